// File: rtl/gray_frame_streamer.sv
// Raster-order gray pixel source: reads a W x H frame from a synchronous RAM and
// streams it with HBLANK idle cycles after each row. Optional macro: GRAY_STREAM_TESTPAT_EN.
module gray_frame_streamer #(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int HBLANK       = 4,
  parameter int ADDR_W       = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef GRAY_STREAM_TESTPAT_EN
  input  logic              testpat,
`endif
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              gray_valid,
  output logic [7:0]        gray,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic [15:0]       pix_row,
  output logic [15:0]       pix_col,
  output logic              frame_done
);

  localparam int COL_W = $clog2(IMAGE_WIDTH);
  localparam int ROW_W = $clog2(IMAGE_HEIGHT);
  localparam int CNT_W = (HBLANK > 2) ? $clog2(HBLANK) : 1;

  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [CNT_W-1:0] LAST_BLNK = CNT_W'(HBLANK - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_BLANK = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t              state_q;
  logic [COL_W-1:0]    col_q;
  logic [ROW_W-1:0]    row_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                issue_q;
  logic                busy_q;
  logic                rd_en_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                done_q;

  logic                tp_q;
  logic                tp_start;

  // Test-pattern select is latched at start so it cannot change mid-frame.
`ifdef GRAY_STREAM_TESTPAT_EN
  assign tp_start = testpat;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp_q <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      tp_q <= testpat;
    end
  end
`else
  assign tp_start = 1'b0;
  assign tp_q     = 1'b0;
`endif

  // Frame sequencer; row_q/col_q/addr_q describe the pixel read in this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      issue_q <= 1'b0;
      busy_q  <= 1'b0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_READ;
            busy_q  <= 1'b1;
            issue_q <= 1'b1;
            rd_en_q <= ~tp_start;
            addr_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
          end
        end
        S_READ: begin
          if (col_q == LAST_COL) begin
            if (row_q == LAST_ROW) begin
              state_q <= S_DRAIN;
              issue_q <= 1'b0;
              rd_en_q <= 1'b0;
              cnt_q   <= '0;
            end else if (HBLANK > 0) begin
              state_q <= S_BLANK;
              issue_q <= 1'b0;
              rd_en_q <= 1'b0;
              cnt_q   <= '0;
              addr_q  <= addr_q + ADDR_W'(1);
            end else begin
              col_q  <= '0;
              row_q  <= row_q + ROW_W'(1);
              addr_q <= addr_q + ADDR_W'(1);
            end
          end else begin
            col_q  <= col_q + COL_W'(1);
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        S_BLANK: begin
          if (cnt_q == LAST_BLNK) begin
            state_q <= S_READ;
            issue_q <= 1'b1;
            rd_en_q <= ~tp_q;
            col_q   <= '0;
            row_q   <= row_q + ROW_W'(1);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          // Two cycles for RAM + output register, then one cycle of frame_done.
          if (done_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else if (cnt_q == CNT_W'(1)) begin
            done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Stage 1: align coordinates and markers with the RAM read latency.
  logic             s1_valid_q;
  logic             s1_sof_q;
  logic             s1_eol_q;
  logic             s1_eof_q;
  logic [COL_W-1:0] s1_col_q;
  logic [ROW_W-1:0] s1_row_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sof_q   <= 1'b0;
      s1_eol_q   <= 1'b0;
      s1_eof_q   <= 1'b0;
      s1_col_q   <= '0;
      s1_row_q   <= '0;
    end else begin
      s1_valid_q <= issue_q;
      s1_sof_q   <= issue_q && (row_q == '0) && (col_q == '0);
      s1_eol_q   <= issue_q && (col_q == LAST_COL);
      s1_eof_q   <= issue_q && (col_q == LAST_COL) && (row_q == LAST_ROW);
      s1_col_q   <= col_q;
      s1_row_q   <= row_q;
    end
  end

  logic [15:0] tp_sum;
  assign tp_sum = 16'(s1_row_q) + 16'(s1_col_q);

  // Stage 2: output register; pixel value and coordinates hold between strobes.
  logic        gv_q;
  logic [7:0]  gray_q;
  logic        sof_q;
  logic        eol_q;
  logic        eof_q;
  logic [15:0] prow_q;
  logic [15:0] pcol_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gv_q   <= 1'b0;
      gray_q <= '0;
      sof_q  <= 1'b0;
      eol_q  <= 1'b0;
      eof_q  <= 1'b0;
      prow_q <= '0;
      pcol_q <= '0;
    end else begin
      gv_q  <= s1_valid_q;
      sof_q <= s1_sof_q;
      eol_q <= s1_eol_q;
      eof_q <= s1_eof_q;
      if (s1_valid_q) begin
        gray_q <= tp_q ? tp_sum[7:0] : mem_rdata;
        prow_q <= 16'(s1_row_q);
        pcol_q <= 16'(s1_col_q);
      end
    end
  end

  assign busy       = busy_q;
  assign rd_en      = rd_en_q;
  assign mem_addr   = addr_q;
  assign frame_done = done_q;
  assign gray_valid = gv_q;
  assign gray       = gray_q;
  assign sof        = sof_q;
  assign eol        = eol_q;
  assign eof        = eof_q;
  assign pix_row    = prow_q;
  assign pix_col    = pcol_q;

endmodule

// File: tb/tb_gray_frame_streamer.sv
// Bench for gray_frame_streamer: two instances (HBLANK=2 and HBLANK=0) checked
// cycle by cycle against a frame-position model derived from the raster timing.
module tb_gray_frame_streamer;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int HBA = 2;
  localparam int HBB = 0;
  localparam int AW  = $clog2(W * H);

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic start_a, start_b, testpat;
  logic [7:0] mem [W*H];

  logic          busy_a, rd_en_a, gv_a, sof_a, eol_a, eof_a, done_a;
  logic [AW-1:0] addr_a;
  logic [7:0]    rdata_a, gray_a;
  logic [15:0]   row_a, col_a;
  logic          busy_b, rd_en_b, gv_b, sof_b, eol_b, eof_b, done_b;
  logic [AW-1:0] addr_b;
  logic [7:0]    rdata_b, gray_b;
  logic [15:0]   row_b, col_b;

  gray_frame_streamer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .HBLANK(HBA)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
`ifdef GRAY_STREAM_TESTPAT_EN
    .testpat(testpat),
`endif
    .busy(busy_a), .rd_en(rd_en_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
    .gray_valid(gv_a), .gray(gray_a), .sof(sof_a), .eol(eol_a), .eof(eof_a),
    .pix_row(row_a), .pix_col(col_a), .frame_done(done_a)
  );

  gray_frame_streamer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .HBLANK(HBB)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
`ifdef GRAY_STREAM_TESTPAT_EN
    .testpat(testpat),
`endif
    .busy(busy_b), .rd_en(rd_en_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
    .gray_valid(gv_b), .gray(gray_b), .sof(sof_b), .eol(eol_b), .eof(eof_b),
    .pix_row(row_b), .pix_col(col_b), .frame_done(done_b)
  );

  // synchronous frame RAM models
  always @(posedge clk) begin
    if (rd_en_a) rdata_a <= (int'(addr_a) < W * H) ? mem[int'(addr_a)] : 8'h00;
    if (rd_en_b) rdata_b <= (int'(addr_b) < W * H) ? mem[int'(addr_b)] : 8'h00;
  end

  // observed-output mux selecting the instance under test
  logic          sel;
  logic          o_busy, o_rd, o_gv, o_sof, o_eol, o_eof, o_done;
  logic [AW-1:0] o_addr;
  logic [7:0]    o_gray;
  logic [15:0]   o_row, o_col;
  assign o_busy = sel ? busy_b  : busy_a;
  assign o_rd   = sel ? rd_en_b : rd_en_a;
  assign o_addr = sel ? addr_b  : addr_a;
  assign o_gv   = sel ? gv_b    : gv_a;
  assign o_gray = sel ? gray_b  : gray_a;
  assign o_sof  = sel ? sof_b   : sof_a;
  assign o_eol  = sel ? eol_b   : eol_a;
  assign o_eof  = sel ? eof_b   : eof_a;
  assign o_row  = sel ? row_b   : row_a;
  assign o_col  = sel ? col_b   : col_a;
  assign o_done = sel ? done_b  : done_a;

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input bit v);
    if (sel) start_b = v; else start_a = v;
  endtask

  // One frame from the start pulse, checked each cycle k after start edge E0.
  // Pixel (r,c) is read in cycle r*(W+hb)+c and appears on gray two cycles later.
  task automatic run_frame(input bit use_b, input bit tp, input bit inject);
    int hb, period, last, pos, r, c, rr, rc;
    bit exp_v, exp_rd, have_px;
    logic [7:0] last_gray, eg;
    hb      = use_b ? HBB : HBA;
    period  = W + hb;
    last    = W * H + (H - 1) * hb + 2;
    have_px = 1'b0;
    last_gray = 8'h00;
    sel     = use_b;
    testpat = tp;
    exp_q.delete();
    for (int i = 0; i < W * H; i++)
      exp_q.push_back(tp ? 8'((i / W) + (i % W)) : mem[i]);
    set_start(1'b1);
    @(posedge clk);
    #1;
    set_start(1'b0);
    testpat = ~tp;
    for (int k = 0; k <= last + 1; k++) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      pos   = k - 2;
      exp_v = 1'b0;
      r = 0; c = 0;
      if (pos >= 0) begin
        r = pos / period;
        c = pos % period;
        exp_v = (r < H) && (c < W);
      end
      rr = k / period;
      rc = k % period;
      exp_rd = !tp && (rr < H) && (rc < W);
      check_eq($sformatf("k%0d valid", k), o_gv, exp_v);
      check_eq($sformatf("k%0d busy", k), o_busy, k <= last);
      check_eq($sformatf("k%0d done", k), o_done, k == last);
      check_eq($sformatf("k%0d rd_en", k), o_rd, exp_rd);
      if (exp_rd) check_eq($sformatf("k%0d addr", k), o_addr, rr * W + rc);
      if (exp_v) begin
        eg = exp_q.pop_front();
        check_eq($sformatf("k%0d gray", k), o_gray, eg);
        check_eq($sformatf("k%0d sof", k), o_sof, (r == 0) && (c == 0));
        check_eq($sformatf("k%0d eol", k), o_eol, c == W - 1);
        check_eq($sformatf("k%0d eof", k), o_eof, (r == H - 1) && (c == W - 1));
        check_eq($sformatf("k%0d row", k), o_row, r);
        check_eq($sformatf("k%0d col", k), o_col, c);
        last_gray = eg;
        have_px   = 1'b1;
      end else begin
        check_eq($sformatf("k%0d markers", k), {o_sof, o_eol, o_eof}, 3'b000);
        if (have_px) check_eq($sformatf("k%0d hold", k), o_gray, last_gray);
      end
      set_start(inject && (k == 5 || k == last));
    end
    set_start(1'b0);
    check_eq("all pixels seen", exp_q.size(), 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq($sformatf("idle%0d", i), {o_busy, o_gv, o_done, o_rd}, 4'b0000);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " ctl"}, {busy_a, rd_en_a, gv_a, sof_a, eol_a, eof_a, done_a}, 7'd0);
    check_eq({tag, " addr"}, addr_a, 0);
    check_eq({tag, " gray"}, gray_a, 0);
    check_eq({tag, " rowcol"}, {row_a, col_a}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; testpat = 1'b0; sel = 1'b0;
    for (int i = 0; i < W * H; i++) mem[i] = 8'(i + 16);
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    check_eq("reset b", {busy_b, rd_en_b, gv_b, done_b}, 4'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // RAM[i]=i+16 with blanking, then back-to-back rows
    run_frame(1'b0, 1'b0, 1'b0);
    idle_cycles(2);
    run_frame(1'b1, 1'b0, 1'b0);
    idle_cycles(2);

    // starts mid-frame and in the frame_done cycle are dropped
    for (int i = 0; i < W * H; i++) mem[i] = 8'($urandom_range(0, 255));
    run_frame(1'b0, 1'b0, 1'b1);
    idle_cycles(4);
    run_frame(1'b0, 1'b0, 1'b1);
    run_frame(1'b0, 1'b0, 1'b0);
    idle_cycles(2);

    // asynchronous reset during row 1
    sel = 1'b0;
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_all_zero("abort");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check_eq($sformatf("post-abort %0d", i), {done_a, busy_a, gv_a}, 3'b000);
    end
    run_frame(1'b0, 1'b0, 1'b0);

    // randomized frames on both instances
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < W * H; i++) mem[i] = 8'($urandom);
      run_frame(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
      idle_cycles($urandom_range(1, 3));
    end

`ifdef GRAY_STREAM_TESTPAT_EN
    run_frame(1'b0, 1'b1, 1'b0);
    idle_cycles(1);
    run_frame(1'b1, 1'b1, 1'b0);
    idle_cycles(1);
    run_frame(1'b0, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
